// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_pkg
// Description : Shared definitions for the inter-stage pipeline registers.
//               Holds the handshake state encoding and the bit positions of
//               the ID/EX control vector, so that every stage packs and
//               unpacks control bits identically.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy state of a pipeline stage register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_FULL  = 2'd1,  // main register holds an entry
    ST_SKID  = 2'd2   // main and skid registers both hold entries
  } pipe_state_e;

  // ID/EX control-vector bit positions.
  localparam int CTRL_REG_DEST   = 0;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_OP_LO  = 4;
  localparam int CTRL_ALU_OP_HI  = 5;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_REG_WRITE  = 8;
  localparam int CTRL_JUMP       = 9;
  localparam int CTRL_IDEX_W     = 10;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic pipeline stage register carrying a data payload and
//               a control vector between two pipeline stages. Provides a
//               valid/ready handshake backed by a 2-entry skid buffer (full
//               throughput under backpressure), flush with bubble insertion,
//               synchronous reset and a saturating stall counter.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   flush         in   discard every held entry and the same-cycle input
//   in_valid      in   upstream presents an entry
//   in_ready      out  stage can accept an entry (registered)
//   in_data       in   upstream data payload   [DATA_W]
//   in_ctrl       in   upstream control bits   [CTRL_W]
//   out_valid     out  downstream entry valid
//   out_ready     in   downstream accepts this cycle
//   out_data      out  payload from the main register
//   out_ctrl      out  control from the main register, zero when not valid
//   stall_cnt     out  saturating count of out_valid & ~out_ready cycles
//   clr_stall_cnt in   synchronous clear of stall_cnt
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int CTRL_W      = 10,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   clr_stall_cnt
);

  pipe_state_e             state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [DATA_W-1:0]       main_data_q, main_data_d;
  logic [CTRL_W-1:0]       main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]       skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]       skid_ctrl_q, skid_ctrl_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  assign out_data  = main_data_q;
  // Masking here turns any invalid cycle (including post-flush) into a bubble
  // without having to clear the main register.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign stall_cnt = stall_cnt_q;

  // --------------------------------------------------------------------------
  // Next-state and datapath steering
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Held entries and any same-cycle input are dropped; main keeps its
      // stale payload, which is hidden by the out_ctrl mask.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            // Downstream stalled while upstream already committed: park the
            // new entry behind the one being presented.
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = ST_SKID;
          end else if (out_fire) begin
            state_d     = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // Ready is registered from the next state so it never depends
    // combinationally on out_ready.
    in_ready_d = (state_d != ST_SKID);
  end

  // --------------------------------------------------------------------------
  // Saturating stall counter
  // --------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_stall_cnt) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg. Inputs are
//               driven 1 time unit after the rising edge and outputs are
//               checked at that point, i.e. they reflect the edge just taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int DATA_W      = 128;
  localparam int CTRL_W      = 10;
  localparam int STALL_CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic [CTRL_W-1:0]      in_ctrl;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic                   clr_stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .stall_cnt     (stall_cnt),
    .clr_stall_cnt (clr_stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_ctrl       = '0;
    out_ready     = 1'b0;
    clr_stall_cnt = 1'b0;
    tick();

    // Handshake offered while reset is held must be ignored.
    in_valid  = 1'b1;
    in_data   = 128'h1234;
    in_ctrl   = 10'h3FF;
    out_ready = 1'b1;
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl",  out_ctrl, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_stall",     stall_cnt, 0);

    reset = 1'b0;
    #1;
    chk("rel_c0_out_valid", out_valid, 0);
    chk("rel_c0_in_ready",  in_ready, 1);
    tick();
    chk("rel_c1_out_valid", out_valid, 1);
    chk("rel_c1_out_data",  out_data, 128'h1234);
    chk("rel_c1_out_ctrl",  out_ctrl, 10'h3FF);
    in_valid = 1'b0;
    tick();
    chk("rel_drain_valid", out_valid, 0);
    chk("rel_drain_ctrl",  out_ctrl, 0);

    // Streaming: one entry per cycle, zero bubbles.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 128'(i);
      in_ctrl  = 10'(i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data, 128'(i));
      chk("stream_ctrl",  out_ctrl, 10'(i));
      chk("stream_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", out_valid, 0);
    chk("stream_stall",     stall_cnt, 0);

    // Backpressure: 1 in main, 2 in skid, 3 held upstream.
    in_valid = 1'b1;
    in_data  = 128'd1;
    in_ctrl  = 10'h001;
    tick();
    out_ready = 1'b0;
    in_data   = 128'd2;
    in_ctrl   = 10'h002;
    tick();
    chk("bp_skid_ready", in_ready, 0);
    chk("bp_skid_data",  out_data, 1);
    in_data = 128'd3;
    in_ctrl = 10'h003;
    tick();
    tick();
    chk("bp_hold_data",  out_data, 1);
    chk("bp_hold_ctrl",  out_ctrl, 10'h001);
    chk("bp_stall_cnt",  stall_cnt, 3);
    out_ready = 1'b1;
    tick();
    chk("bp_out2_data",  out_data, 2);
    chk("bp_out2_ready", in_ready, 1);
    tick();
    chk("bp_out3_data",  out_data, 3);
    in_valid = 1'b0;
    tick();
    chk("bp_end_valid",  out_valid, 0);
    chk("bp_end_stall",  stall_cnt, 3);

    // Flush in SKID with a simultaneous offer.
    clr_stall_cnt = 1'b1;
    tick();
    clr_stall_cnt = 1'b0;
    chk("clr_stall", stall_cnt, 0);
    in_valid  = 1'b1;
    in_data   = 128'hA;
    in_ctrl   = 10'h155;
    out_ready = 1'b0;
    tick();
    in_data = 128'hB;
    in_ctrl = 10'h2AA;
    tick();
    chk("fl_pre_ready", in_ready, 0);
    flush   = 1'b1;
    in_data = 128'hC;
    in_ctrl = 10'h0CC;
    tick();
    flush = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_ctrl",  out_ctrl, 0);
    chk("fl_in_ready",  in_ready, 1);
    chk("fl_stall_kept", stall_cnt, 2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", out_valid, 0);
    in_valid = 1'b1;
    in_data  = 128'hD;
    in_ctrl  = 10'h00D;
    tick();
    chk("fl_next_data", out_data, 128'hD);
    chk("fl_next_ctrl", out_ctrl, 10'h00D);
    in_valid = 1'b0;
    tick();

    // Stall counter saturation and clear priority.
    clr_stall_cnt = 1'b1;
    tick();
    clr_stall_cnt = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'hE;
    in_ctrl   = 10'h00E;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall",     stall_cnt, 15);
    chk("sat_hold_data", out_data, 128'hE);
    clr_stall_cnt = 1'b1;
    tick();
    chk("sat_clr", stall_cnt, 0);
    clr_stall_cnt = 1'b0;
    tick();
    chk("sat_restart", stall_cnt, 1);

    // Reset while in SKID drops both entries.
    in_valid = 1'b1;
    in_data  = 128'h21;
    in_ctrl  = 10'h021;
    tick();
    chk("rs_skid_ready", in_ready, 0);
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_out_data",  out_data, 0);
    chk("rs_out_ctrl",  out_ctrl, 0);
    chk("rs_in_ready",  in_ready, 1);
    chk("rs_stall",     stall_cnt, 0);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rs_no_skid_emit", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire
